fm_param_meas: RTL



---
 rtl/fm_param_meas.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/fm_param_meas.sv
// fm_param_meas: windowed FM measurement of modulation frequency, peak deviation and mf = delta_f / mod_freq.
// Optional macro FM_MEAS_AVG_EN: report 4-window moving averages of mod_freq and delta_f.
module fm_param_meas #(
    parameter int unsigned DW         = 10,
    parameter int unsigned FW         = 16,
    parameter int unsigned WIN_CYC    = 100000,
    parameter int unsigned HYST       = 4,
    parameter int unsigned CROSS_GAIN = 500,
    parameter int unsigned DF_GAIN    = 1,
    parameter int unsigned MF_FRAC    = 4,
    parameter int unsigned MFW        = 12
) (
    input  logic           clk_100m,
    input  logic           rst,
    input  logic           s_valid,
    input  logic [DW-1:0]  s_data,
    input  logic [DW-1:0]  mid_value,
    output logic           meas_valid,
    output logic [FW-1:0]  mod_freq,
    output logic [FW-1:0]  delta_f,
    output logic [MFW-1:0] mf,
    output logic           div_zero,
    output logic           sat
);
    localparam int unsigned CW  = $clog2(WIN_CYC + 1);
    localparam int unsigned WCW = $clog2(WIN_CYC);
    localparam int unsigned QW  = FW + MF_FRAC;
    localparam int unsigned QCW = $clog2(QW + 1);
    localparam logic [DW-1:0]  D_MAX  = '1;
    localparam logic [FW-1:0]  F_MAX  = '1;
    localparam logic [MFW-1:0] MF_MAX = '1;

    typedef enum logic [1:0] {X_UNKNOWN, X_ABOVE, X_BELOW} xing_t;
    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

    logic [WCW-1:0] win_cnt;
    logic           win_end;
    logic [DW-1:0]  mid_q, peak_pos, peak_neg;
    logic [CW-1:0]  cross_cnt;
    xing_t          xing;

    logic [31:0]    hi_w;
    logic [DW-1:0]  thr_hi, thr_lo;
    logic [CW-1:0]  cnt_nx;
    xing_t          xing_nx;
    logic [DW-1:0]  pos_nx, neg_nx;
    logic [DW-1:0]  exc_pos, exc_neg, exc;
    logic [63:0]    f_full, d_full;
    logic           f_clip, d_clip;
    logic [FW-1:0]  f_win, d_win, f_load, d_load;

    assign win_end = (win_cnt == WCW'(WIN_CYC - 1));

    always_comb begin
        hi_w   = 32'(mid_q) + HYST;
        thr_hi = (hi_w > 32'(D_MAX)) ? D_MAX : hi_w[DW-1:0];
        thr_lo = (32'(mid_q) < HYST) ? '0 : DW'(32'(mid_q) - HYST);
    end

    // Next-cycle tracker state; at window end these include the closing sample.
    always_comb begin
        cnt_nx  = cross_cnt;
        xing_nx = xing;
        pos_nx  = peak_pos;
        neg_nx  = peak_neg;
        if (s_valid) begin
            if (s_data >= thr_hi) begin
                xing_nx = X_ABOVE;
                if (xing == X_BELOW && cross_cnt != '1) cnt_nx = cross_cnt + 1'b1;
            end else if (s_data <= thr_lo) begin
                xing_nx = X_BELOW;
                if (xing == X_ABOVE && cross_cnt != '1) cnt_nx = cross_cnt + 1'b1;
            end
            if (s_data > peak_pos) pos_nx = s_data;
            if (s_data < peak_neg) neg_nx = s_data;
        end
    end

    always_comb begin
        exc_pos = pos_nx - mid_q;
        exc_neg = mid_q - neg_nx;
        exc     = (exc_pos > exc_neg) ? exc_pos : exc_neg;
        f_full  = 64'(cnt_nx) * 64'(CROSS_GAIN);
        d_full  = 64'(exc) * 64'(DF_GAIN);
        f_clip  = f_full > 64'(F_MAX);
        d_clip  = d_full > 64'(F_MAX);
        f_win   = f_clip ? F_MAX : f_full[FW-1:0];
        d_win   = d_clip ? F_MAX : d_full[FW-1:0];
    end

    always_ff @(posedge clk_100m) begin
        if (rst || win_end) begin
            win_cnt   <= '0;
            mid_q     <= mid_value;
            peak_pos  <= mid_value;
            peak_neg  <= mid_value;
            cross_cnt <= '0;
            xing      <= X_UNKNOWN;
        end else begin
            win_cnt   <= win_cnt + 1'b1;
            peak_pos  <= pos_nx;
            peak_neg  <= neg_nx;
            cross_cnt <= cnt_nx;
            xing      <= xing_nx;
        end
    end

`ifdef FM_MEAS_AVG_EN
    logic [FW-1:0] f_hist [3];
    logic [FW-1:0] d_hist [3];
    logic [FW+1:0] f_sum, d_sum;

    always_comb begin
        f_sum  = (FW+2)'(f_win) + (FW+2)'(f_hist[0]) + (FW+2)'(f_hist[1]) + (FW+2)'(f_hist[2]);
        d_sum  = (FW+2)'(d_win) + (FW+2)'(d_hist[0]) + (FW+2)'(d_hist[1]) + (FW+2)'(d_hist[2]);
        f_load = FW'(f_sum >> 2);
        d_load = FW'(d_sum >> 2);
    end

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                f_hist[i] <= '0;
                d_hist[i] <= '0;
            end
        end else if (win_end) begin
            f_hist[0] <= f_win;
            f_hist[1] <= f_hist[0];
            f_hist[2] <= f_hist[1];
            d_hist[0] <= d_win;
            d_hist[1] <= d_hist[0];
            d_hist[2] <= d_hist[1];
        end
    end
`else
    assign f_load = f_win;
    assign d_load = d_win;
`endif

    div_state_t      div_state;
    logic [FW-1:0]   f_q, d_q, rem;
    logic [QW-1:0]   quo;
    logic [QCW-1:0]  bit_cnt;
    logic            sat_q, dz_q;
    logic [FW:0]     trial;
    logic            trial_ge;
    logic [QW+MFW-1:0] qx;
    logic            q_ovf;

    // quo starts as the dividend and shifts quotient bits in from the right.
    assign trial    = {rem, quo[QW-1]};
    assign trial_ge = trial >= {1'b0, f_q};
    assign qx       = {{MFW{1'b0}}, quo};
    assign q_ovf    = qx > {{QW{1'b0}}, MF_MAX};

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            div_state  <= DIV_IDLE;
            f_q        <= '0;
            d_q        <= '0;
            rem        <= '0;
            quo        <= '0;
            bit_cnt    <= '0;
            sat_q      <= 1'b0;
            dz_q       <= 1'b0;
            meas_valid <= 1'b0;
            mod_freq   <= '0;
            delta_f    <= '0;
            mf         <= '0;
            div_zero   <= 1'b0;
            sat        <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (div_state)
                DIV_IDLE: begin
                    if (win_end) begin
                        f_q       <= f_load;
                        d_q       <= d_load;
                        sat_q     <= f_clip | d_clip;
                        dz_q      <= (f_load == '0);
                        rem       <= '0;
                        bit_cnt   <= '0;
                        quo       <= QW'(d_load) << MF_FRAC;
                        div_state <= (f_load == '0) ? DIV_DONE : DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    rem     <= trial_ge ? FW'(trial - {1'b0, f_q}) : trial[FW-1:0];
                    quo     <= {quo[QW-2:0], trial_ge};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == QCW'(QW - 1)) div_state <= DIV_DONE;
                end
                DIV_DONE: begin
                    meas_valid <= 1'b1;
                    mod_freq   <= f_q;
                    delta_f    <= d_q;
                    div_zero   <= dz_q;
                    if (dz_q) begin
                        mf  <= '1;
                        sat <= sat_q;
                    end else if (q_ovf) begin
                        mf  <= '1;
                        sat <= 1'b1;
                    end else begin
                        mf  <= qx[MFW-1:0];
                        sat <= sat_q;
                    end
                    div_state <= DIV_IDLE;
                end
                default: div_state <= DIV_IDLE;
            endcase
        end
    end
endmodule
